mgnt_reg_hub: RTL
=================

// Module: mgnt_reg_hub
// PURPOSE
//  Parametrised SPI-to-management register hub: decodes 16-bit SPI pointer writes into byte-serial
//  read/write transactions towards NUM_DEV remote register blocks (ports, BE/TTE switch cores), and
//  serves local registers (ID, features, status, flow-table staging) directly. Adds per-transaction
//  timeout, sticky error/overrun status and a FT_WORDS-deep flow-table staging buffer.
// PARAMETERS
//  NUM_DEV        8       remote device channels; device id 0..NUM_DEV-1 (<=64)
//  MGNT_REG_WIDTH 32      remote register width, multiple of 16; NB=MGNT_REG_WIDTH/8 bytes
//  FT_WORDS       8       16-bit flow staging words; flow width 16*FT_WORDS
//  TIMEOUT_CYC    1024    max cycles from request start to sys_req_ack
//  SW_ID_VAL      16'h1234  value of local reg 0x80
//  SW_FTR_VAL     16'h001F  value of local reg 0x81
// PORTS
//  clk                 in   1        system clock
//  rst                 in   1        synchronous reset, active low
//  spi_wr              in   1        SPI write strobe, 1 cycle
//  spi_op              in   7        SPI op/register select
//  spi_din             in   16       SPI write data
//  spi_ack             out  1        = spi_wr (combinational)
//  spi_dout            out  16       read-return value
//  busy                out  1        transaction in flight (state != IDLE)
//  sys_req_valid       out  NUM_DEV  one-hot device select, held until ack/timeout
//  sys_req_wr          out  1        1=write, 0=read; held with valid
//  sys_req_addr        out  8        remote register address = ptr[7:0]
//  sys_req_ack         in   1        remote completion
//  sys_req_data        out  8        write byte, MSB byte first
//  sys_req_data_valid  out  1        write byte strobe
//  sys_resp_data       in   8        read byte, MSB byte first
//  sys_resp_data_valid in   1        read byte strobe
//  ft_update, ft_clear out  1        flow-table commands, held until ft_ack
//  ft_ack              in   1        flow-table completion
//  flow                out  16*FT_WORDS  staged flow entry
//  hash                out  12       staged hash
// BEHAVIOUR
//  - All outputs/regs 0 on rst low at clk edge; state=IDLE. Reset mid-transaction aborts cleanly.
//  - SPI ops: 0x00 PTR (start txn), 0x10+k WDATA slice k (k<MGNT_REG_WIDTH/16), 0x02 FT_CTRL,
//    0x03 HASH, 0x30+j FT word j (j<FT_WORDS). Unlisted ops ignored. ptr={wr,dev[6:0],addr[7:0]}.
//  - FSM: IDLE -> (spi_wr&op==0) DECODE. DECODE: dev<NUM_DEV -> REQ; dev==0x7F -> LOCAL;
//    else -> DONE with err_dec set. REQ: valid[dev]=1, wr=ptr[15]; write streams NB bytes on
//    consecutive cycles from wdata MSB; read shifts NB resp bytes into rdata; -> WAIT_ACK after
//    last byte. WAIT_ACK: ack -> DONE, drop valid/wr same edge. LOCAL -> DONE. DONE -> IDLE.
//  - Timeout: counter starts at REQ entry; reaching TIMEOUT_CYC in REQ/WAIT_ACK drops valid/wr/
//    data_valid, sets sticky err_to, rdata=all-ones, -> DONE.
//  - spi_dout loaded in DONE: remote read -> rdata[15:0]; local -> selected local reg; write -> 0.
//  - Local regs (addr): 0x10+k rdata slice k; 0x20+k wdata slice k; 0x02 {14'b0,ft_bsy};
//    0x03 hash; 0x30+j FT word j; 0x40 status {13'b0,ovr,err_dec,err_to}; 0x80 ID; 0x81 FTR;
//    unmapped -> 0. Local write to 0x40 (ptr[15]=1) clears status with spi_din mask bits.
//  - PTR write while busy: ignored, sets sticky ovr. WDATA/FT/HASH writes accepted any time.
//  - FT_CTRL write: din==1 -> ft_update, din==2 -> ft_clear, else ignored; ignored while either
//    asserted. Command held until ft_ack, cleared next edge; ft_bsy mirrors {clear,update}.
//  - Response bytes outside REQ-read are ignored; extra bytes after NB ignored.
// TESTING
//  - ptr 0x0105 read, dev1 returns AA BB CC DD then ack -> valid=0x02, rdata 0xAABBCCDD, dout 0xCCDD.
//  - wdata 0x1234/0x5678 (slices1/0), ptr 0x8304 -> bytes 12 34 56 78 on dev3, wr=1, dout 0.
//  - dev4 read, no ack -> valid drops at TIMEOUT_CYC, status bit0=1, slice0 reads 0xFFFF.
//  - ptr 0x0900 (dev 9, NUM_DEV=8) -> no valid asserted, status bit1=1; PTR during busy -> bit2=1.
//  - FT words 0x30..0x37 + hash 0xABC, FT_CTRL=1 -> ft_update held until ft_ack, flow/hash match.
//  - rst low during WAIT_ACK -> next cycle all outputs 0, IDLE, new PTR accepted.

Source files
------------

// File: rtl/mgnt_reg_hub.sv
// SPI-to-management register hub: turns 16-bit SPI pointer writes into byte-serial
// requests towards NUM_DEV remote register blocks and serves local ID/status/flow-staging registers.
module mgnt_reg_hub #(
    parameter int unsigned NUM_DEV        = 8,
    parameter int unsigned MGNT_REG_WIDTH = 32,
    parameter int unsigned FT_WORDS       = 8,
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter logic [15:0] SW_ID_VAL      = 16'h1234,
    parameter logic [15:0] SW_FTR_VAL     = 16'h001F
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_wr,
    input  logic [6:0]                spi_op,
    input  logic [15:0]               spi_din,
    output logic                      spi_ack,
    output logic [15:0]               spi_dout,
    output logic                      busy,
    output logic [NUM_DEV-1:0]        sys_req_valid,
    output logic                      sys_req_wr,
    output logic [7:0]                sys_req_addr,
    input  logic                      sys_req_ack,
    output logic [7:0]                sys_req_data,
    output logic                      sys_req_data_valid,
    input  logic [7:0]                sys_resp_data,
    input  logic                      sys_resp_data_valid,
    output logic                      ft_update,
    output logic                      ft_clear,
    input  logic                      ft_ack,
    output logic [16*FT_WORDS-1:0]    flow,
    output logic [11:0]               hash
);

    localparam int unsigned NB        = MGNT_REG_WIDTH / 8;
    localparam int unsigned NW        = MGNT_REG_WIDTH / 16;
    localparam int unsigned CNT_W     = (NB > 2) ? $clog2(NB) : 1;
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FLOW_W    = 16 * FT_WORDS;
    localparam int unsigned DEV_W     = 7;
    localparam logic [6:0]  OP_PTR    = 7'h00;
    localparam logic [6:0]  OP_FTCTRL = 7'h02;
    localparam logic [6:0]  OP_HASH   = 7'h03;
    localparam logic [6:0]  LOCAL_DEV = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_REQ,
        S_WAIT_ACK,
        S_LOCAL,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [15:0]                ptr_q, ptr_d;
    logic [MGNT_REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic [MGNT_REG_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic                       err_to_q, err_to_d;
    logic                       err_dec_q, err_dec_d;
    logic                       ovr_q, ovr_d;
    logic [15:0]                dout_q, dout_d;
    logic                       busy_q, busy_d;
    logic [NUM_DEV-1:0]         valid_q, valid_d;
    logic                       wr_q, wr_d;
    logic [7:0]                 addr_q, addr_d;
    logic [7:0]                 data_q, data_d;
    logic                       dv_q, dv_d;
    logic                       ft_upd_q, ft_upd_d;
    logic                       ft_clr_q, ft_clr_d;
    logic [FLOW_W-1:0]          ft_q, ft_d;
    logic [11:0]                hash_q, hash_d;

    logic [DEV_W-1:0]           ptr_dev;
    logic                       ptr_wr;
    logic                       dev_ok;
    logic                       ptr_stb;
    logic                       last_byte;
    logic                       timeout_hit;
    logic [15:0]                local_rd;

    assign ptr_dev     = ptr_q[14:8];
    assign ptr_wr      = ptr_q[15];
    assign dev_ok      = (ptr_dev < DEV_W'(NUM_DEV));
    assign ptr_stb     = spi_wr && (spi_op == OP_PTR);
    assign last_byte   = (cnt_q == CNT_W'(NB - 1));
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Byte idx of the write register, counted from the most significant byte.
    function automatic logic [7:0] wbyte(input logic [MGNT_REG_WIDTH-1:0] w,
                                         input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx == CNT_W'(i)) b = w[MGNT_REG_WIDTH-1-8*i -: 8];
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (ptr_stb) state_d = S_DECODE;
            S_DECODE: begin
                if (dev_ok)                    state_d = S_REQ;
                else if (ptr_dev == LOCAL_DEV) state_d = S_LOCAL;
                else                           state_d = S_DONE;
            end
            S_REQ: begin
                if (timeout_hit)                                    state_d = S_DONE;
                else if (ptr_wr && last_byte)                       state_d = S_WAIT_ACK;
                else if (!ptr_wr && sys_resp_data_valid && last_byte) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: if (sys_req_ack || timeout_hit) state_d = S_DONE;
            S_LOCAL:    state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Local register read mux, addressed by ptr[7:0].
    always_comb begin
        local_rd = '0;
        case (ptr_q[7:4])
            4'h0: begin
                if (ptr_q[3:0] == 4'h2)      local_rd = {14'b0, ft_clr_q, ft_upd_q};
                else if (ptr_q[3:0] == 4'h3) local_rd = {4'b0, hash_q};
            end
            4'h1: for (int k = 0; k < NW; k++)
                      if (ptr_q[3:0] == 4'(k)) local_rd = rdata_q[16*k +: 16];
            4'h2: for (int k = 0; k < NW; k++)
                      if (ptr_q[3:0] == 4'(k)) local_rd = wdata_q[16*k +: 16];
            4'h3: for (int j = 0; j < FT_WORDS; j++)
                      if (ptr_q[3:0] == 4'(j)) local_rd = ft_q[16*j +: 16];
            4'h4: if (ptr_q[3:0] == 4'h0) local_rd = {13'b0, ovr_q, err_dec_q, err_to_q};
            4'h8: begin
                if (ptr_q[3:0] == 4'h0)      local_rd = SW_ID_VAL;
                else if (ptr_q[3:0] == 4'h1) local_rd = SW_FTR_VAL;
            end
            default: ;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        err_to_d  = err_to_q;
        err_dec_d = err_dec_q;
        ovr_d     = ovr_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dv_d      = dv_q;
        ft_upd_d  = ft_upd_q;
        ft_clr_d  = ft_clr_q;
        ft_d      = ft_q;
        hash_d    = hash_q;
        busy_d    = (state_d != S_IDLE);

        if (spi_wr) begin
            for (int k = 0; k < NW; k++)
                if (spi_op == 7'(16 + k)) wdata_d[16*k +: 16] = spi_din;
            for (int j = 0; j < FT_WORDS; j++)
                if (spi_op == 7'(48 + j)) ft_d[16*j +: 16] = spi_din;
            if (spi_op == OP_HASH) hash_d = spi_din[11:0];
        end

        // A flow-table command stays up until acknowledged; new commands wait for that.
        if (ft_upd_q || ft_clr_q) begin
            if (ft_ack) begin
                ft_upd_d = 1'b0;
                ft_clr_d = 1'b0;
            end
        end else if (spi_wr && (spi_op == OP_FTCTRL)) begin
            ft_upd_d = (spi_din == 16'd1);
            ft_clr_d = (spi_din == 16'd2);
        end

        case (state_q)
            S_DECODE: begin
                if (dev_ok) begin
                    valid_d  = NUM_DEV'(1) << ptr_dev;
                    wr_d     = ptr_wr;
                    addr_d   = ptr_q[7:0];
                    cnt_d    = '0;
                    to_cnt_d = '0;
                    dv_d     = ptr_wr;
                    data_d   = ptr_wr ? wbyte(wdata_q, '0) : 8'h00;
                end else if (ptr_dev != LOCAL_DEV) begin
                    err_dec_d = 1'b1;
                end
            end
            S_REQ: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (timeout_hit) begin
                    valid_d  = '0;
                    wr_d     = 1'b0;
                    dv_d     = 1'b0;
                    data_d   = '0;
                    err_to_d = 1'b1;
                    rdata_d  = '1;
                end else if (ptr_wr) begin
                    if (last_byte) begin
                        dv_d   = 1'b0;
                        data_d = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        data_d = wbyte(wdata_q, cnt_q + CNT_W'(1));
                    end
                end else if (sys_resp_data_valid) begin
                    rdata_d = {rdata_q[MGNT_REG_WIDTH-9:0], sys_resp_data};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (sys_req_ack) begin
                    valid_d = '0;
                    wr_d    = 1'b0;
                end else if (timeout_hit) begin
                    valid_d  = '0;
                    wr_d     = 1'b0;
                    err_to_d = 1'b1;
                    rdata_d  = '1;
                end
            end
            S_LOCAL: begin
                // Status clear takes its mask from the SPI data bus while the local access runs.
                if (ptr_wr && (ptr_q[7:0] == 8'h40)) begin
                    if (spi_din[0]) err_to_d  = 1'b0;
                    if (spi_din[1]) err_dec_d = 1'b0;
                    if (spi_din[2]) ovr_d     = 1'b0;
                end
            end
            S_DONE: begin
                if (ptr_dev == LOCAL_DEV)    dout_d = ptr_wr ? 16'h0000 : local_rd;
                else if (dev_ok && !ptr_wr)  dout_d = rdata_q[15:0];
                else                         dout_d = 16'h0000;
            end
            default: ;
        endcase

        if (ptr_stb) begin
            if (state_q == S_IDLE) ptr_d = spi_din;
            else                   ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            err_to_q  <= 1'b0;
            err_dec_q <= 1'b0;
            ovr_q     <= 1'b0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            ft_upd_q  <= 1'b0;
            ft_clr_q  <= 1'b0;
            ft_q      <= '0;
            hash_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_to_q  <= err_to_d;
            err_dec_q <= err_dec_d;
            ovr_q     <= ovr_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            ft_upd_q  <= ft_upd_d;
            ft_clr_q  <= ft_clr_d;
            ft_q      <= ft_d;
            hash_q    <= hash_d;
        end
    end

    assign spi_ack            = spi_wr;
    assign spi_dout           = dout_q;
    assign busy               = busy_q;
    assign sys_req_valid      = valid_q;
    assign sys_req_wr         = wr_q;
    assign sys_req_addr       = addr_q;
    assign sys_req_data       = data_q;
    assign sys_req_data_valid = dv_q;
    assign ft_update          = ft_upd_q;
    assign ft_clear           = ft_clr_q;
    assign flow               = ft_q;
    assign hash               = hash_q;

endmodule
